// File: rtl/zculling_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zculling_pkg
// Brief    : Shared types and field layout for the depth-test stage.
// Revision : 1.0 - initial release
// ============================================================================
package zculling_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_RD_CNT   = 3'd2,
        ST_FRAG_IN  = 3'd3,
        ST_FRAG_CMP = 3'd4,
        ST_OUT_CNT  = 3'd5,
        ST_OUT_PIX  = 3'd6
    } state_t;

    // Every field of an incoming fragment / outgoing pixel is one byte wide
    localparam int unsigned c_field_bits = 8;

    // Incoming fragment word: {color, z, y, x}
    localparam int unsigned c_frag_x_lsb = 0;
    localparam int unsigned c_frag_y_lsb = 8;
    localparam int unsigned c_frag_z_lsb = 16;
    localparam int unsigned c_frag_c_lsb = 24;

    // Outgoing pixel word: {8'h0, color, y, x}
    localparam int unsigned c_pix_x_lsb = 0;
    localparam int unsigned c_pix_y_lsb = 8;
    localparam int unsigned c_pix_c_lsb = 16;

    // Farthest possible depth; every Z entry starts each frame at this value
    localparam logic [7:0] Z_INIT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/zculling_if.sv
`default_nettype none
// ============================================================================
// Module   : zculling_if
// Brief    : 32-bit word stream with ap_vld/ap_ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface zculling_if;
    logic [31:0] V_V;
    logic        V_V_ap_vld;
    logic        V_V_ap_ack;

    modport master (
        output V_V,
        output V_V_ap_vld,
        input  V_V_ap_ack
    );

    modport slave (
        input  V_V,
        input  V_V_ap_vld,
        output V_V_ap_ack
    );
endinterface
`default_nettype wire

// File: rtl/zculling_ram.sv
`default_nettype none
// ============================================================================
// Module   : zculling_ram
// Brief    : Simple dual-port RAM, one write port, one synchronous read port.
//            Read-during-write to the same address returns the old contents.
// Revision : 1.0 - initial release
// ============================================================================
module zculling_ram #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  wire                  clk,
    input  wire                  i_we,
    input  wire [ADDR_BITS-1:0]  i_waddr,
    input  wire [DATA_BITS-1:0]  i_wdata,
    input  wire [ADDR_BITS-1:0]  i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/zculling_stage.sv
`default_nettype none
// ============================================================================
// Module   : zculling_stage
// Brief    : Depth test. Clears a per-pixel Z-buffer, keeps fragments nearer
//            than the stored depth, buffers survivors and emits
//            {count, pixels...} on the output stream.
// Revision : 1.0 - initial release
// ============================================================================
module zculling_stage
    import zculling_pkg::*;
#(
    parameter int COORD_BITS    = 8,
    parameter int Z_BITS        = 8,
    parameter int BUF_ADDR_BITS = 11
) (
    input  wire        ap_clk,
    input  wire        ap_rst_n,
    input  wire        ap_start,
    output logic       ap_idle,
    output logic       ap_done,
    output logic       ap_ready,
    output logic       overflow,
    zculling_if.slave  Input_1,
    zculling_if.master Output_1
);

    localparam int c_zb_addr_bits = 2 * COORD_BITS;
    localparam int c_pix_bits     = c_field_bits + 2 * COORD_BITS;
    localparam logic [BUF_ADDR_BITS:0] c_buf_full = {1'b1, {BUF_ADDR_BITS{1'b0}}};

    state_t                      r_state;
    state_t                      w_state_next;

    logic [c_zb_addr_bits-1:0]   r_clr_addr;
    logic [15:0]                 r_frag_total;
    logic [15:0]                 r_frag_cnt;
    logic [15:0]                 w_frag_cnt_inc;
    logic [COORD_BITS-1:0]       r_x;
    logic [COORD_BITS-1:0]       r_y;
    logic [Z_BITS-1:0]           r_z;
    logic [7:0]                  r_color;
    logic [BUF_ADDR_BITS:0]      r_surv_cnt;
    logic [BUF_ADDR_BITS:0]      r_rd_ptr;
    logic                        r_overflow;
    logic                        r_out_vld;
    logic [31:0]                 r_out_data;

    logic                        w_in_ack;
    logic                        w_in_xfer;
    logic                        w_out_xfer;
    logic                        w_done;
    logic                        w_pass;
    logic                        w_buf_full;

    logic                        w_zb_we;
    logic [c_zb_addr_bits-1:0]   w_zb_waddr;
    logic [Z_BITS-1:0]           w_zb_wdata;
    logic [c_zb_addr_bits-1:0]   w_zb_raddr;
    logic [Z_BITS-1:0]           w_zb_rdata;

    logic                        w_sb_we;
    logic [c_pix_bits-1:0]       w_sb_wdata;
    logic [BUF_ADDR_BITS:0]      w_sb_rptr;
    logic [c_pix_bits-1:0]       w_sb_rdata;
    logic [31:0]                 w_pix_word;

    assign w_in_xfer      = Input_1.V_V_ap_vld & w_in_ack;
    assign w_out_xfer     = r_out_vld & Output_1.V_V_ap_ack;
    assign w_pass         = (r_z < w_zb_rdata);
    assign w_buf_full     = (r_surv_cnt == c_buf_full);
    assign w_frag_cnt_inc = r_frag_cnt + 16'd1;

    // Z-buffer: CLEAR owns the write port, otherwise the depth test does.
    // The read address comes straight off the input so the stored depth is
    // ready the cycle after the fragment is accepted.
    assign w_zb_waddr = (r_state == ST_CLEAR) ? r_clr_addr : {r_y, r_x};
    assign w_zb_wdata = (r_state == ST_CLEAR) ? Z_INIT[Z_BITS-1:0] : r_z;
    assign w_zb_raddr = {Input_1.V_V[c_frag_y_lsb +: COORD_BITS],
                         Input_1.V_V[c_frag_x_lsb +: COORD_BITS]};

    zculling_ram #(
        .ADDR_BITS (c_zb_addr_bits),
        .DATA_BITS (Z_BITS)
    ) u_zbuf (
        .clk     (ap_clk),
        .i_we    (w_zb_we),
        .i_waddr (w_zb_waddr),
        .i_wdata (w_zb_wdata),
        .i_raddr (w_zb_raddr),
        .o_rdata (w_zb_rdata)
    );

    // Survivor buffer: the read side looks one entry ahead on every output
    // transfer so the next pixel is already in the RAM output register.
    assign w_sb_wdata = {r_color, r_y, r_x};
    assign w_sb_rptr  = w_out_xfer ? (r_rd_ptr + 1'b1) : r_rd_ptr;

    zculling_ram #(
        .ADDR_BITS (BUF_ADDR_BITS),
        .DATA_BITS (c_pix_bits)
    ) u_sbuf (
        .clk     (ap_clk),
        .i_we    (w_sb_we),
        .i_waddr (r_surv_cnt[BUF_ADDR_BITS-1:0]),
        .i_wdata (w_sb_wdata),
        .i_raddr (w_sb_rptr[BUF_ADDR_BITS-1:0]),
        .o_rdata (w_sb_rdata)
    );

    // Unpack a stored survivor into the outgoing pixel word layout
    always_comb begin
        w_pix_word = '0;
        w_pix_word[c_pix_x_lsb +: COORD_BITS]   = w_sb_rdata[0 +: COORD_BITS];
        w_pix_word[c_pix_y_lsb +: COORD_BITS]   = w_sb_rdata[COORD_BITS +: COORD_BITS];
        w_pix_word[c_pix_c_lsb +: c_field_bits] = w_sb_rdata[2*COORD_BITS +: c_field_bits];
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_state_next = r_state;
        w_in_ack     = 1'b0;
        w_zb_we      = 1'b0;
        w_sb_we      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_zb_we = 1'b1;
                if (r_clr_addr == {c_zb_addr_bits{1'b1}}) w_state_next = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                w_in_ack = 1'b1;
                if (Input_1.V_V_ap_vld) begin
                    w_state_next = (Input_1.V_V[15:0] == 16'd0) ? ST_OUT_CNT : ST_FRAG_IN;
                end
            end
            ST_FRAG_IN: begin
                w_in_ack = 1'b1;
                if (Input_1.V_V_ap_vld) w_state_next = ST_FRAG_CMP;
            end
            ST_FRAG_CMP: begin
                if (w_pass) begin
                    w_zb_we = 1'b1;
                    w_sb_we = !w_buf_full;
                end
                w_state_next = (w_frag_cnt_inc == r_frag_total) ? ST_OUT_CNT : ST_FRAG_IN;
            end
            ST_OUT_CNT: begin
                if (w_out_xfer) begin
                    if (r_surv_cnt == '0) begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_OUT_PIX;
                    end
                end
            end
            ST_OUT_PIX: begin
                if (w_out_xfer && (r_rd_ptr == r_surv_cnt)) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counters, fragment capture and sticky overflow
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_clr_addr   <= '0;
            r_frag_total <= '0;
            r_frag_cnt   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_color      <= '0;
            r_surv_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_clr_addr <= '0;
                        r_frag_cnt <= '0;
                        r_surv_cnt <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                end
                ST_RD_CNT: begin
                    if (w_in_xfer) r_frag_total <= Input_1.V_V[15:0];
                end
                ST_FRAG_IN: begin
                    if (w_in_xfer) begin
                        r_x     <= Input_1.V_V[c_frag_x_lsb +: COORD_BITS];
                        r_y     <= Input_1.V_V[c_frag_y_lsb +: COORD_BITS];
                        r_z     <= Input_1.V_V[c_frag_z_lsb +: Z_BITS];
                        r_color <= Input_1.V_V[c_frag_c_lsb +: c_field_bits];
                    end
                end
                ST_FRAG_CMP: begin
                    r_frag_cnt <= w_frag_cnt_inc;
                    if (w_pass && !w_buf_full) r_surv_cnt <= r_surv_cnt + 1'b1;
                    if (w_pass && w_buf_full)  r_overflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered output word: count on the first OUT_CNT cycle, then the
    // survivor held in the RAM output register on each transfer
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_vld <= 1'b0;
                    if (ap_start) r_rd_ptr <= '0;
                end
                ST_OUT_CNT: begin
                    if (!r_out_vld) begin
                        r_out_vld  <= 1'b1;
                        r_out_data <= {16'h0, 16'(r_surv_cnt)};
                    end else if (w_out_xfer) begin
                        if (r_surv_cnt == '0) begin
                            r_out_vld <= 1'b0;
                        end else begin
                            r_out_data <= w_pix_word;
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                ST_OUT_PIX: begin
                    if (w_out_xfer) begin
                        if (r_rd_ptr == r_surv_cnt) begin
                            r_out_vld <= 1'b0;
                        end else begin
                            r_out_data <= w_pix_word;
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_idle             = (r_state == ST_IDLE);
    assign ap_done             = w_done;
    assign ap_ready            = w_done;
    assign overflow            = r_overflow;
    assign Input_1.V_V_ap_ack  = w_in_ack;
    assign Output_1.V_V        = r_out_data;
    assign Output_1.V_V_ap_vld = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_zculling_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_zculling_stage
// Brief    : Directed self-checking bench for zculling_stage (4x4 Z-buffer,
//            4-entry survivor buffer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zculling_stage;

    logic ap_clk;
    logic ap_rst_n;
    logic ap_start;
    logic ap_idle;
    logic ap_done;
    logic ap_ready;
    logic overflow;

    zculling_if in_bus();
    zculling_if out_bus();

    int checks = 0;
    int errors = 0;

    zculling_stage #(
        .COORD_BITS    (2),
        .Z_BITS        (8),
        .BUF_ADDR_BITS (2)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .ap_ready (ap_ready),
        .overflow (overflow),
        .Input_1  (in_bus),
        .Output_1 (out_bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] frag(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] z, input logic [7:0] c);
        return {c, z, y, x};
    endfunction

    function automatic logic [31:0] pix(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] c);
        return {8'h00, c, y, x};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse ap_start for one cycle; called at a falling edge
    task automatic start_frame();
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    // Offer one word upstream and wait for it to be accepted
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_bus.V_V        = w;
        in_bus.V_V_ap_vld = 1'b1;
        while (!in_bus.V_V_ap_ack && n < 2000) begin
            @(negedge ap_clk);
            n++;
        end
        check("input ack timeout", {31'd0, in_bus.V_V_ap_ack}, 32'd1);
        @(negedge ap_clk);
        in_bus.V_V_ap_vld = 1'b0;
    endtask

    // Wait for a valid output word, optionally stall it, then accept it
    task automatic recv(input string tag, input logic [31:0] exp,
                        input logic exp_done, input int hold);
        int n = 0;
        while (!out_bus.V_V_ap_vld && n < 2000) begin
            @(negedge ap_clk);
            n++;
        end
        check({tag, " vld timeout"}, {31'd0, out_bus.V_V_ap_vld}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            check({tag, " held data"}, out_bus.V_V, exp);
            check({tag, " held vld"}, {31'd0, out_bus.V_V_ap_vld}, 32'd1);
            @(negedge ap_clk);
        end
        out_bus.V_V_ap_ack = 1'b1;
        #1;
        check({tag, " data"}, out_bus.V_V, exp);
        check({tag, " ap_done"}, {31'd0, ap_done}, {31'd0, exp_done});
        check({tag, " ap_ready"}, {31'd0, ap_ready}, {31'd0, exp_done});
        @(negedge ap_clk);
        out_bus.V_V_ap_ack = 1'b0;
    endtask

    initial begin
        ap_rst_n           = 1'b1;
        ap_start           = 1'b0;
        in_bus.V_V         = '0;
        in_bus.V_V_ap_vld  = 1'b0;
        out_bus.V_V_ap_ack = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #3 ap_rst_n = 1'b0;
        #1;
        check("reset ap_idle",   {31'd0, ap_idle}, 32'd1);
        check("reset ap_done",   {31'd0, ap_done}, 32'd0);
        check("reset ap_ready",  {31'd0, ap_ready}, 32'd0);
        check("reset overflow",  {31'd0, overflow}, 32'd0);
        check("reset out vld",   {31'd0, out_bus.V_V_ap_vld}, 32'd0);
        check("reset out data",  out_bus.V_V, 32'd0);
        check("reset in ack",    {31'd0, in_bus.V_V_ap_ack}, 32'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Nearer fragment arrives second: both survive
        start_frame();
        send_word(32'd2);
        send_word(frag(8'd1, 8'd2, 8'd10, 8'hAA));
        send_word(frag(8'd1, 8'd2, 8'd5,  8'hBB));
        recv("A count", 32'd2, 1'b0, 0);
        recv("A pix0", pix(8'd1, 8'd2, 8'hAA), 1'b0, 0);
        recv("A pix1", pix(8'd1, 8'd2, 8'hBB), 1'b1, 0);
        check("A idle after", {31'd0, ap_idle}, 32'd1);
        check("A vld after",  {31'd0, out_bus.V_V_ap_vld}, 32'd0);

        // Farther fragment arrives second: it is culled
        start_frame();
        send_word(32'd2);
        send_word(frag(8'd1, 8'd2, 8'd5,  8'hBB));
        send_word(frag(8'd1, 8'd2, 8'd10, 8'hAA));
        recv("B count", 32'd1, 1'b0, 0);
        recv("B pix0", pix(8'd1, 8'd2, 8'hBB), 1'b1, 0);

        // Empty frame: only the count word, which carries ap_done
        start_frame();
        send_word(32'd0);
        recv("N0 count", 32'd0, 1'b1, 0);
        check("N0 idle after", {31'd0, ap_idle}, 32'd1);

        // Backpressure in the middle of the pixel stream
        start_frame();
        send_word(32'd3);
        send_word(frag(8'd0, 8'd0, 8'd1, 8'h11));
        send_word(frag(8'd1, 8'd0, 8'd1, 8'h22));
        send_word(frag(8'd2, 8'd1, 8'd1, 8'h33));
        recv("BP count", 32'd3, 1'b0, 0);
        recv("BP pix0", pix(8'd0, 8'd0, 8'h11), 1'b0, 0);
        recv("BP pix1", pix(8'd1, 8'd0, 8'h22), 1'b0, 5);
        recv("BP pix2", pix(8'd2, 8'd1, 8'h33), 1'b1, 0);
        check("BP vld after", {31'd0, out_bus.V_V_ap_vld}, 32'd0);

        // Six survivors into a four-entry buffer
        start_frame();
        send_word(32'd6);
        for (int i = 0; i < 6; i++) begin
            send_word(frag(8'(i % 4), 8'(i / 4), 8'd1, 8'(8'h40 + i)));
        end
        recv("OVF count", 32'd4, 1'b0, 0);
        recv("OVF pix0", pix(8'd0, 8'd0, 8'h40), 1'b0, 0);
        recv("OVF pix1", pix(8'd1, 8'd0, 8'h41), 1'b0, 0);
        recv("OVF pix2", pix(8'd2, 8'd0, 8'h42), 1'b0, 0);
        recv("OVF pix3", pix(8'd3, 8'd0, 8'h43), 1'b1, 0);
        check("OVF overflow set", {31'd0, overflow}, 32'd1);

        // Next start clears overflow; this frame leaves z=3 at (0,0)
        start_frame();
        check("OVF overflow cleared", {31'd0, overflow}, 32'd0);
        send_word(32'd1);
        send_word(frag(8'd0, 8'd0, 8'd3, 8'h77));
        recv("CLR1 count", 32'd1, 1'b0, 0);
        recv("CLR1 pix0", pix(8'd0, 8'd0, 8'h77), 1'b1, 0);

        // A far fragment at the same pixel passes again after the clear
        start_frame();
        send_word(32'd1);
        send_word(frag(8'd0, 8'd0, 8'd200, 8'h88));
        recv("CLR2 count", 32'd1, 1'b0, 0);
        recv("CLR2 pix0", pix(8'd0, 8'd0, 8'h88), 1'b1, 0);

        // Reset while waiting for the second of three fragments
        start_frame();
        send_word(32'd3);
        send_word(frag(8'd1, 8'd1, 8'd9, 8'h55));
        @(negedge ap_clk);
        check("MID in FRAG_IN ack", {31'd0, in_bus.V_V_ap_ack}, 32'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("MID reset idle", {31'd0, ap_idle}, 32'd1);
        check("MID reset ack",  {31'd0, in_bus.V_V_ap_ack}, 32'd0);
        check("MID reset vld",  {31'd0, out_bus.V_V_ap_vld}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        start_frame();
        send_word(32'd2);
        send_word(frag(8'd1, 8'd1, 8'd50, 8'h99));
        send_word(frag(8'd1, 8'd1, 8'd60, 8'h9A));
        recv("POST count", 32'd1, 1'b0, 0);
        recv("POST pix0", pix(8'd1, 8'd1, 8'h99), 1'b1, 0);
        check("POST overflow", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
